md_unit: RTL and testbench

//   Multiply/divide sequencer owning the HI/LO register pair for the P6 pipeline.

---
 rtl/md_unit.sv | 128 ++++++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide sequencer: latches the result on Start, holds Busy for a
// fixed countdown, then commits HI/LO in the cycle Busy falls.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_hi_tmp;
  logic [31:0]     r_lo_tmp;
  logic            r_div0;
  logic            r_busy;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic [63:0]     w_prod_s;
  logic [63:0]     w_prod_u;
  logic            w_div0;
  logic            w_ovf;
  logic [31:0]     w_b_safe;
  logic [31:0]     w_qs;
  logic [31:0]     w_rs;
  logic [31:0]     w_qu;
  logic [31:0]     w_ru;
  logic [31:0]     w_hi_res;
  logic [31:0]     w_lo_res;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Divisor is forced to 1 on B==0 so the dividers never see zero; the
  // result is discarded at commit anyway.
  assign w_div0   = (B == 32'd0);
  assign w_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_b_safe = w_div0 ? 32'd1 : B;
  assign w_qs     = $signed(A) / $signed(w_b_safe);
  assign w_rs     = $signed(A) % $signed(w_b_safe);
  assign w_qu     = A / w_b_safe;
  assign w_ru     = A % w_b_safe;

  always_comb begin
    w_hi_res = 32'd0;
    w_lo_res = 32'd0;
    case (MDOp)
      2'b00: begin
        w_hi_res = w_prod_s[63:32];
        w_lo_res = w_prod_s[31:0];
      end
      2'b01: begin
        w_hi_res = w_prod_u[63:32];
        w_lo_res = w_prod_u[31:0];
      end
      2'b10: begin
        w_hi_res = w_ovf ? 32'd0 : w_rs;
        w_lo_res = w_ovf ? 32'h8000_0000 : w_qs;
      end
      default: begin
        w_hi_res = w_ru;
        w_lo_res = w_qu;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_hi_tmp <= 32'd0;
      r_lo_tmp <= 32'd0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_hi_tmp <= w_hi_res;
            r_lo_tmp <= w_lo_res;
            r_div0   <= MDOp[1] & w_div0;
            r_count  <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            if (HIWrite) r_hi <= A;
            if (LOWrite) r_lo <= A;
          end
        end
        RUN: begin
          // Start/HIWrite/LOWrite are deliberately ignored while running.
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            if (!r_div0) begin
              r_hi <= r_hi_tmp;
              r_lo <= r_lo_tmp;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops,
// checked against a 64-bit arithmetic model of HI/LO and Busy duration.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO after an op, from plain 64-bit integer arithmetic.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    longint          q;
    longint          r;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      2'b01: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      2'b10: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) - q * longint'($signed(b));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      default: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
    endcase
  endtask

  // Called and returns at a negedge; consecutive calls are back-to-back.
  task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit with_low, input bit poke);
    int cnt;
    int exp_n;
    exp_n = op[1] ? DIV_N : MULT_N;
    Start = 1'b1; MDOp = op; A = a; B = b; LOWrite = with_low; HIWrite = 1'b0;
    @(negedge clk);
    Start = 1'b0; LOWrite = 1'b0; A = $urandom; B = $urandom;
    chk("busy_rise", {31'd0, Busy}, 32'd1);
    chk("hi_hold", HI, m_hi);
    chk("lo_hold", LO, m_lo);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (poke && cnt == 3) begin
        $display("note: protocol-violating Start/HIWrite injected during RUN");
        Start = 1'b1; MDOp = ~op; HIWrite = 1'b1; A = 32'hDEAD_BEEF; B = 32'd7;
      end else if (poke && cnt == 4) begin
        Start = 1'b0; HIWrite = 1'b0;
      end
      @(negedge clk);
    end
    model_op(op, a, b);
    chk("busy_cycles", cnt, exp_n);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    $display("op=%0d a=%h b=%h cycles=%0d HI=%h LO=%h", op, a, b, cnt, HI, LO);
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
    HIWrite = hw; LOWrite = lw; A = a;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    if (hw) m_hi = a;
    if (lw) m_lo = a;
    chk("mt_hi", HI, m_hi);
    chk("mt_lo", LO, m_lo);
    chk("mt_busy", {31'd0, Busy}, 32'd0);
    $display("mt hw=%0d lw=%0d a=%h HI=%h LO=%h", hw, lw, a, HI, LO);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; MDOp = 2'b00; A = 32'd0; B = 32'd0;
    HIWrite = 1'b0; LOWrite = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-DIV discards the pending result.
    mt(1'b1, 1'b1, 32'h1234_5678);
    Start = 1'b1; MDOp = 2'b11; A = 32'd100; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_busy", {31'd0, Busy}, 32'd0);
    chk("postrst_hi", HI, 32'd0);
    chk("postrst_lo", LO, 32'd0);
    $display("reset mid-DIV HI=%h LO=%h", HI, LO);

    // Directed arithmetic corners.
    do_md(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFFA);
    do_md(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("multu_hi_const", HI, 32'h0000_0002);
    do_md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    do_md(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_lo_const", LO, 32'd3);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    do_md(2'b10, 32'd99, 32'd0, 1'b0, 1'b0);
    chk("div0_hi_const", HI, 32'h11);
    chk("div0_lo_const", LO, 32'h22);
    do_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo_const", LO, 32'h8000_0000);
    chk("ovf_hi_const", HI, 32'd0);
    do_md(2'b00, 32'd9, 32'd7, 1'b1, 1'b0);
    chk("start_wins_lo", LO, 32'd63);
    do_md(2'b01, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b1);
    mt(1'b1, 1'b0, 32'hABCD);
    mt(1'b1, 1'b1, 32'h5A5A_0001);

    // Back-to-back then randomized ops interleaved with MTHI/MTLO.
    do_md(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    do_md(2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      do_md(op, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
